// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver/transmitter state
// encoding and the oversampling divider calculation.
package uart_pkg;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_ODD  = 1;
   localparam int unsigned PAR_EVEN = 2;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;

   // Clocks per oversample tick, rounded to nearest.
   function automatic int unsigned calc_div(input int unsigned clk_freq,
                                            input int unsigned baud,
                                            input int unsigned oversample);
      int unsigned den;
      den = baud * oversample;
      return (clk_freq + den / 2) / den;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every C_DIV clocks.
module uart_baud_tick #(
   parameter int unsigned C_DIV = 54
) (
   input  logic sysClk,
   input  logic sysRst,
   output logic oTick
);

   localparam int unsigned CW = (C_DIV > 1) ? $clog2(C_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(C_DIV - 1);

   logic [CW-1:0] cnt_q;

   // Count 0..C_DIV-1 and wrap.
   always_ff @(posedge sysClk) begin
      if (sysRst) begin
         cnt_q <= '0;
      end else if (cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign oTick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, LSB-first deserialisation,
// parity/stop checking and a valid/ready output with sticky overrun.
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 voting around each
// bit decision point.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned C_CLK_FREQ        = 100000000,
   parameter int unsigned C_UART_BAUD       = 115200,
   parameter int unsigned C_UART_DATA_WIDTH = 8,
   parameter int unsigned C_UART_PARITY     = 1,
   parameter int unsigned C_UART_STOP       = 1,
   parameter int unsigned C_OVERSAMPLE      = 16
) (
   input  logic                         sysClk,
   input  logic                         sysRst,
   input  logic                         rx,
   output logic [C_UART_DATA_WIDTH-1:0] oData,
   output logic                         oValid,
   input  logic                         iReady,
   output logic                         oParityErr,
   output logic                         oFrameErr,
   output logic                         oOverrun,
   output logic                         oBusy
);

   localparam int unsigned DIV = calc_div(C_CLK_FREQ, C_UART_BAUD, C_OVERSAMPLE);
   localparam int unsigned W   = C_UART_DATA_WIDTH;
   localparam int unsigned SCW = $clog2(C_OVERSAMPLE);
   localparam int unsigned BCW = 4;
   localparam int unsigned MID = C_OVERSAMPLE / 2 - 1;
   localparam logic [SCW-1:0] SC_LAST = SCW'(C_OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
   // Last of the three votes lands one tick after mid-bit.
   localparam logic [SCW-1:0] SC_START = SCW'(MID + 1);
`else
   localparam logic [SCW-1:0] SC_START = SCW'(MID);
`endif

   logic rx_meta_q, rx_s_q;
   logic tick;
   logic bit_val;

   uart_state_e    state_q;
   logic [SCW-1:0] sc_q;
   logic [BCW-1:0] bc_q;
   logic [W-1:0]   shreg_q;
   logic           armed_q, par_err_q, frm_err_q;

   logic           parity_bad, done, done_ferr;

   logic [W-1:0]   data_q;
   logic           valid_q, perr_q, ferr_q, ovr_q;

   // Two-flop synchroniser for the asynchronous line, idle-high reset.
   always_ff @(posedge sysClk) begin
      if (sysRst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   uart_baud_tick #(
      .C_DIV (DIV)
   ) u_baud_tick (
      .sysClk (sysClk),
      .sysRst (sysRst),
      .oTick  (tick)
   );

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] vote_q;

   // Keep the line value from the previous two ticks for voting.
   always_ff @(posedge sysClk) begin
      if (sysRst) begin
         vote_q <= 2'b11;
      end else if (tick) begin
         vote_q <= {vote_q[0], rx_s_q};
      end
   end

   assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s_q) | (vote_q[1] & rx_s_q);
`else
   assign bit_val = rx_s_q;
`endif

   // Parity check and frame-completion detection.
   always_comb begin
      parity_bad = (C_UART_PARITY == PAR_EVEN) ? (^{shreg_q, bit_val}) : ~(^{shreg_q, bit_val});
      done       = tick && (state_q == STOP) && (sc_q == SC_LAST) &&
                   (bc_q == BCW'(C_UART_STOP - 1));
      done_ferr  = frm_err_q | ~bit_val;
   end

   // Receive FSM; after START every decision falls on the sc wrap.
   always_ff @(posedge sysClk) begin
      if (sysRst) begin
         state_q   <= IDLE;
         sc_q      <= '0;
         bc_q      <= '0;
         shreg_q   <= '0;
         armed_q   <= 1'b0;
         par_err_q <= 1'b0;
         frm_err_q <= 1'b0;
      end else if (tick) begin
         sc_q <= (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
         unique case (state_q)
            IDLE: begin
               if (rx_s_q) begin
                  armed_q <= 1'b1;
               end else if (armed_q) begin
                  sc_q      <= '0;
                  bc_q      <= '0;
                  par_err_q <= 1'b0;
                  frm_err_q <= 1'b0;
                  state_q   <= START;
               end
            end
            START: begin
               if (sc_q == SC_START) begin
                  if (bit_val) begin
                     state_q <= IDLE;
                  end else begin
                     sc_q    <= '0;
                     state_q <= DATA;
                  end
               end
            end
            DATA: begin
               if (sc_q == SC_LAST) begin
                  shreg_q <= {bit_val, shreg_q[W-1:1]};
                  if (bc_q == BCW'(W - 1)) begin
                     bc_q    <= '0;
                     state_q <= (C_UART_PARITY != PAR_NONE) ? PARITY : STOP;
                  end else begin
                     bc_q <= bc_q + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (sc_q == SC_LAST) begin
                  par_err_q <= parity_bad;
                  state_q   <= STOP;
               end
            end
            STOP: begin
               if (sc_q == SC_LAST) begin
                  if (!bit_val) frm_err_q <= 1'b1;
                  if (bc_q == BCW'(C_UART_STOP - 1)) begin
                     state_q <= IDLE;
                     // A low stop bit (break) disarms until the line idles high.
                     armed_q <= bit_val;
                  end else begin
                     bc_q <= bc_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Output register: load on completion, drop with overrun if unaccepted.
   always_ff @(posedge sysClk) begin
      if (sysRst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else if (done) begin
         if (!valid_q || iReady) begin
            data_q  <= shreg_q;
            perr_q  <= par_err_q;
            ferr_q  <= done_ferr;
            valid_q <= 1'b1;
            if (valid_q) ovr_q <= 1'b0;
         end else begin
            ovr_q <= 1'b1;
         end
      end else if (valid_q && iReady) begin
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end
   end

   assign oData      = data_q;
   assign oValid     = valid_q;
   assign oParityErr = perr_q;
   assign oFrameErr  = ferr_q;
   assign oOverrun   = ovr_q;
   assign oBusy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx. Clock chosen so DIV = 4 (64 clocks per bit).
// Instance A: 8 data bits, odd parity, 1 stop. Instance B: 5 bits, even, 2 stop.
module tb_uart_rx;

   localparam int unsigned CLK_FREQ = 7372800;
   localparam int unsigned BAUD     = 115200;
   localparam int          BITCLK   = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_a = 1'b1, rx_b = 1'b1;
   logic       rdy_a = 1'b0, rdy_b = 1'b0;
   logic [7:0] data_a;
   logic [4:0] data_b;
   logic       val_a, val_b, perr_a, perr_b, ferr_a, ferr_b, ovr_a, ovr_b, busy_a, busy_b;

   int  errors = 0;
   int  checks = 0;
   time t0 = 0, t_rise = 0;
   logic val_prev = 1'b0, busy_prev = 1'b0, busy_at_rise = 1'b1, busy_prev_at_rise = 1'b0;
   longint lat;

   always #5 clk = ~clk;

   uart_rx #(
      .C_CLK_FREQ (CLK_FREQ), .C_UART_BAUD (BAUD), .C_UART_DATA_WIDTH (8),
      .C_UART_PARITY (1), .C_UART_STOP (1), .C_OVERSAMPLE (16)
   ) dut_a (
      .sysClk (clk), .sysRst (rst), .rx (rx_a), .oData (data_a), .oValid (val_a),
      .iReady (rdy_a), .oParityErr (perr_a), .oFrameErr (ferr_a), .oOverrun (ovr_a),
      .oBusy (busy_a)
   );

   uart_rx #(
      .C_CLK_FREQ (CLK_FREQ), .C_UART_BAUD (BAUD), .C_UART_DATA_WIDTH (5),
      .C_UART_PARITY (2), .C_UART_STOP (2), .C_OVERSAMPLE (16)
   ) dut_b (
      .sysClk (clk), .sysRst (rst), .rx (rx_b), .oData (data_b), .oValid (val_b),
      .iReady (rdy_b), .oParityErr (perr_b), .oFrameErr (ferr_b), .oOverrun (ovr_b),
      .oBusy (busy_b)
   );

   // Record when A's oValid rises and what oBusy looked like around it.
   always @(negedge clk) begin
      if (val_a && !val_prev) begin
         t_rise            <= $time;
         busy_at_rise      <= busy_a;
         busy_prev_at_rise <= busy_prev;
      end
      val_prev  <= val_a;
      busy_prev <= busy_a;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit line_b, input logic v);
      if (line_b) rx_b = v;
      else rx_a = v;
   endtask

   // Send n bits LSB first; optional 1-clock inversion at each bit centre.
   task automatic send(input logic [15:0] bits, input int n, input int bitclk,
                       input bit line_b, input bit glitch);
      for (int i = 0; i < n; i++) begin
         logic b;
         b = bits[i];
         drive(line_b, b);
         if (glitch) begin
            repeat (bitclk / 2) @(negedge clk);
            drive(line_b, ~b);
            @(negedge clk);
            drive(line_b, b);
            repeat (bitclk - bitclk / 2 - 1) @(negedge clk);
         end else begin
            repeat (bitclk) @(negedge clk);
         end
      end
      repeat (10) @(negedge clk);
   endtask

   // {idle, stop, odd parity (optionally wrong), data, start}
   function automatic logic [15:0] frame_a(input logic [7:0] d, input bit par_wrong,
                                           input bit stop);
      return {5'b11111, stop, (~^d) ^ par_wrong, d, 1'b0};
   endfunction

   // {idle, stop, stop, even parity, data, start}
   function automatic logic [15:0] frame_b(input logic [4:0] d);
      return {7'b1111111, 1'b1, 1'b1, ^d, d, 1'b0};
   endfunction

   task automatic accept_a(input string tag);
      rdy_a = 1'b1;
      @(negedge clk);
      rdy_a = 1'b0;
      check(tag, val_a, 1'b0);
   endtask

   task automatic accept_b(input string tag);
      rdy_b = 1'b1;
      @(negedge clk);
      rdy_b = 1'b0;
      check(tag, val_b, 1'b0);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      repeat (5) @(negedge clk);
      check("rst_data", data_a, 8'h00);
      check("rst_valid", val_a, 1'b0);
      check("rst_perr", perr_a, 1'b0);
      check("rst_ferr", ferr_a, 1'b0);
      check("rst_ovr", ovr_a, 1'b0);
      check("rst_busy", busy_a, 1'b0);
      check("rst_valid_b", val_b, 1'b0);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // 1: 0xA5, good odd parity; latency relative to stop mid-sample
      t0 = $time;
      send(frame_a(8'hA5, 1'b0, 1'b1), 11, BITCLK, 1'b0, 1'b0);
      check("a5_valid", val_a, 1'b1);
      check("a5_data", data_a, 8'hA5);
      check("a5_perr", perr_a, 1'b0);
      check("a5_ferr", ferr_a, 1'b0);
      check("a5_busy_at_rise", busy_at_rise, 1'b0);
      check("a5_busy_before_rise", busy_prev_at_rise, 1'b1);
      lat = longint'((t_rise - t0) / 10);
      checks++;
      assert (lat >= 674 && lat <= 683) else begin
         errors++;
         $error("FAIL a5_latency: observed=%0d clocks required=674..683", lat);
      end
      accept_a("a5_accept");

      // 2: wrong parity, then break-like zero frame with low stop
      send(frame_a(8'h3C, 1'b1, 1'b1), 11, BITCLK, 1'b0, 1'b0);
      check("3c_data", data_a, 8'h3C);
      check("3c_perr", perr_a, 1'b1);
      check("3c_ferr", ferr_a, 1'b0);
      accept_a("3c_accept");
      send(frame_a(8'h00, 1'b0, 1'b0), 11, BITCLK, 1'b0, 1'b0);
      check("brk_data", data_a, 8'h00);
      check("brk_ferr", ferr_a, 1'b1);
      check("brk_perr", perr_a, 1'b0);
      rx_a = 1'b1;
      repeat (20) @(negedge clk);
      accept_a("brk_accept");

      // 3: short glitch while idle, then 0x55
      rx_a = 1'b0;
      repeat (10) @(negedge clk);
      check("glitch_busy", busy_a, 1'b1);
      repeat (2) @(negedge clk);
      rx_a = 1'b1;
      repeat (60) @(negedge clk);
      check("glitch_idle", busy_a, 1'b0);
      check("glitch_novalid", val_a, 1'b0);
      send(frame_a(8'h55, 1'b0, 1'b1), 11, BITCLK, 1'b0, 1'b0);
      check("55_data", data_a, 8'h55);
      check("55_valid", val_a, 1'b1);
      accept_a("55_accept");

      // 4: overrun with iReady low
      send(frame_a(8'h11, 1'b0, 1'b1), 11, BITCLK, 1'b0, 1'b0);
      send(frame_a(8'h22, 1'b0, 1'b1), 11, BITCLK, 1'b0, 1'b0);
      check("ovr_data", data_a, 8'h11);
      check("ovr_flag", ovr_a, 1'b1);
      check("ovr_valid", val_a, 1'b1);
      accept_a("ovr_accept");
      check("ovr_cleared", ovr_a, 1'b0);
      send(frame_a(8'h33, 1'b0, 1'b1), 11, BITCLK, 1'b0, 1'b0);
      check("33_data", data_a, 8'h33);
      check("33_ovr", ovr_a, 1'b0);
      check("33_perr", perr_a, 1'b0);
      check("33_ferr", ferr_a, 1'b0);
      accept_a("33_accept");

      // 5: reset during data bits of 0x81
      send(frame_a(8'h81, 1'b0, 1'b1), 4, BITCLK, 1'b0, 1'b0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("mrst_data", data_a, 8'h00);
      check("mrst_busy", busy_a, 1'b0);
      check("mrst_valid", val_a, 1'b0);
      check("mrst_ovr", ovr_a, 1'b0);
      rst = 1'b0;
      send(frame_a(8'h81, 1'b0, 1'b1) >> 4, 7, BITCLK, 1'b0, 1'b0);
      repeat (40) @(negedge clk);
      check("mrst_noword", val_a, 1'b0);
      check("mrst_idle", busy_a, 1'b0);
      send(frame_a(8'h7E, 1'b0, 1'b1), 11, BITCLK, 1'b0, 1'b0);
      check("7e_data", data_a, 8'h7E);
      check("7e_valid", val_a, 1'b1);
      check("7e_perr", perr_a, 1'b0);
      check("7e_ferr", ferr_a, 1'b0);
      accept_a("7e_accept");

      // 6: skewed baud on B (5 bits, even parity, 2 stop)
      send(frame_b(5'h15), 9, 62, 1'b1, 1'b0);
      check("fast_valid", val_b, 1'b1);
      check("fast_data", data_b, 5'h15);
      check("fast_perr", perr_b, 1'b0);
      check("fast_ferr", ferr_b, 1'b0);
      accept_b("fast_accept");
      send(frame_b(5'h15), 9, 66, 1'b1, 1'b0);
      check("slow_valid", val_b, 1'b1);
      check("slow_data", data_b, 5'h15);
      check("slow_perr", perr_b, 1'b0);
      check("slow_ferr", ferr_b, 1'b0);
      accept_b("slow_accept");

`ifdef UART_RX_MAJORITY_EN
      // Mid-bit 1-clock inversions are outvoted.
      send(frame_a(8'hA5, 1'b0, 1'b1), 11, BITCLK, 1'b0, 1'b1);
      check("maj_valid", val_a, 1'b1);
      check("maj_data", data_a, 8'hA5);
      check("maj_perr", perr_a, 1'b0);
      check("maj_ferr", ferr_a, 1'b0);
      accept_a("maj_accept");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
